// File: rtl/defog_recover_if.sv
// Video bus of the defog recovery stage: input pixel/transmittance/syncs
// from upstream and the recovered, sync-aligned pixel stream.
interface defog_recover_if;
    logic [23:0] i_rgb;
    logic [7:0]  i_trans;
    logic [7:0]  i_atmos;
    logic        i_hsync;
    logic        i_vsync;
    logic        i_de;
    logic [23:0] o_rgb;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;

    // upstream / bench side
    modport master (
        output i_rgb, i_trans, i_atmos, i_hsync, i_vsync, i_de,
        input  o_rgb, o_hsync, o_vsync, o_de
    );

    // recovery block side
    modport slave (
        input  i_rgb, i_trans, i_atmos, i_hsync, i_vsync, i_de,
        output o_rgb, o_hsync, o_vsync, o_de
    );
endinterface

// File: rtl/defog_recover.sv
// Haze-free recovery: J = A + (I - A) * 256 / t, clamped to 0..255.
// Stage 0 registers inputs, stages 1..16 form a restoring divider that
// yields floor(65535 / t), stage 17 multiplies, stage 18 shifts, adds A,
// clamps and registers the output. Syncs ride a LAT-deep shift register.
module defog_recover #(
    parameter int         LAT       = 19,     // datapath depth is fixed at 19
    parameter logic [7:0] ATMOS_MIN = 8'd128,
    parameter logic [7:0] T_MIN     = 8'd1
) (
    input  logic         pixelclk,
    input  logic         reset_n,
    defog_recover_if.slave bus
);
    localparam int NCH = 3;
    localparam int QW  = 16;

    // data that travels alongside the divider
    typedef struct packed {
        logic [23:0]          rgb;
        logic [7:0]           a;
        logic [NCH-1:0][8:0]  diff;
        logic                 byp;
    } side_t;

    logic [7:0]           a_frame;
    logic                 vs_prev;

    logic [7:0]           t_floor;
    side_t                side0;

    logic [QW-1:0][7:0]   d_t;
    logic [QW:0][7:0]     d_rem;
    logic [QW:0][QW-1:0]  d_q;
    side_t [QW:0]         d_side;

    logic [QW:1][7:0]     rem_nx;
    logic [QW:1][QW-1:0]  q_nx;
    logic [8:0]           trial;
    logic                 ge;

    logic [NCH-1:0][24:0] prod_nx;
    logic [NCH-1:0][24:0] prod;
    logic signed [24:0]   mul_a;
    logic signed [24:0]   mul_b;
    logic [7:0]           p_a;
    logic [23:0]          p_rgb;
    logic                 p_byp;

    logic [NCH-1:0][7:0]  rgb_nx;
    logic signed [24:0]   s_full;

    logic [LAT-1:0][2:0]  sync_pipe;

    // atmospheric light is latched on the vsync rising edge, held for the frame
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            a_frame <= '0;
            vs_prev <= 1'b0;
        end else begin
            vs_prev <= bus.i_vsync;
            if (bus.i_vsync && !vs_prev)
                a_frame <= bus.i_atmos;
        end
    end

    // stage 0 operands: floored t, signed per-channel I - A, bypass decision
    always_comb begin
        t_floor    = (bus.i_trans < T_MIN) ? T_MIN : bus.i_trans;
        side0      = '0;
        side0.rgb  = bus.i_rgb;
        side0.a    = a_frame;
        side0.byp  = (a_frame < ATMOS_MIN);
        for (int c = 0; c < NCH; c++)
            side0.diff[c] = {1'b0, bus.i_rgb[8*c +: 8]} - {1'b0, a_frame};
    end

    // one restoring-division step per stage; dividend is all ones, so each
    // step shifts in a 1 and the quotient fills MSB first
    always_comb begin
        rem_nx = '0;
        q_nx   = '0;
        trial  = '0;
        ge     = 1'b0;
        for (int k = 1; k <= QW; k++) begin
            trial          = {d_rem[k-1], 1'b1};
            ge             = (trial >= {1'b0, d_t[k-1]});
            rem_nx[k]      = ge ? 8'(trial - {1'b0, d_t[k-1]}) : trial[7:0];
            q_nx[k]        = d_q[k-1];
            q_nx[k][QW-k]  = ge;
        end
    end

    // stage 0 input register plus the 16 divider stages
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            d_t    <= '0;
            d_rem  <= '0;
            d_q    <= '0;
            d_side <= '0;
        end else begin
            d_t[0]    <= t_floor;
            d_rem[0]  <= '0;
            d_q[0]    <= '0;
            d_side[0] <= side0;
            for (int k = 1; k < QW; k++)
                d_t[k] <= d_t[k-1];
            for (int k = 1; k <= QW; k++) begin
                d_rem[k]  <= rem_nx[k];
                d_q[k]    <= q_nx[k];
                d_side[k] <= d_side[k-1];
            end
        end
    end

    // signed diff times unsigned reciprocal, both widened to 25 bits
    always_comb begin
        prod_nx = '0;
        mul_a   = '0;
        mul_b   = '0;
        for (int c = 0; c < NCH; c++) begin
            mul_a      = {{16{d_side[QW].diff[c][8]}}, d_side[QW].diff[c]};
            mul_b      = {9'b0, d_q[QW]};
            prod_nx[c] = mul_a * mul_b;
        end
    end

    // stage 17 product register
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            prod  <= '0;
            p_a   <= '0;
            p_rgb <= '0;
            p_byp <= 1'b0;
        end else begin
            prod  <= prod_nx;
            p_a   <= d_side[QW].a;
            p_rgb <= d_side[QW].rgb;
            p_byp <= d_side[QW].byp;
        end
    end

    // floor-shift by 8, add A back, clamp to the 8-bit range
    always_comb begin
        rgb_nx = '0;
        s_full = '0;
        for (int c = 0; c < NCH; c++) begin
            s_full = ($signed(prod[c]) >>> 8) + $signed({17'b0, p_a});
            if (s_full < 0)
                rgb_nx[c] = 8'd0;
            else if (s_full > 25'sd255)
                rgb_nx[c] = 8'd255;
            else
                rgb_nx[c] = s_full[7:0];
        end
    end

    // stage 18 output register; bypassed frames pass the original pixel
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n)
            bus.o_rgb <= '0;
        else
            bus.o_rgb <= p_byp ? p_rgb : rgb_nx;
    end

    // sync and data-enable delay line matching the datapath depth
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n)
            sync_pipe <= '0;
        else
            sync_pipe <= {sync_pipe[LAT-2:0], {bus.i_hsync, bus.i_vsync, bus.i_de}};
    end

    assign bus.o_hsync = sync_pipe[LAT-1][2];
    assign bus.o_vsync = sync_pipe[LAT-1][1];
    assign bus.o_de    = sync_pipe[LAT-1][0];
endmodule

// File: tb/tb_defog_recover.sv
// Directed bench for defog_recover: bypass frame, recovery arithmetic,
// clamps, A latching, a long random line and a mid-line reset.
module tb_defog_recover;
    localparam int LAT  = 19;
    localparam int MAXV = 2048;

    logic pixelclk = 1'b0;
    logic reset_n  = 1'b0;
    always #5 pixelclk = ~pixelclk;

    defog_recover_if bus ();

    defog_recover #(.LAT(19), .ATMOS_MIN(8'd128), .T_MIN(8'd1)) dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [23:0] v_rgb [0:MAXV-1];
    logic [7:0]  v_t   [0:MAXV-1];
    logic [7:0]  v_a   [0:MAXV-1];
    logic        v_hs  [0:MAXV-1];
    logic        v_vs  [0:MAXV-1];
    logic        v_de  [0:MAXV-1];
    logic [23:0] exp_rgb [0:MAXV-1];
    logic [23:0] cap_rgb [0:MAXV-1];
    logic        cap_hs  [0:MAXV-1];
    logic        cap_vs  [0:MAXV-1];
    logic        cap_de  [0:MAXV-1];
    int          nvec;

    // bench-side frame state used by the golden model
    logic [7:0] model_a  = 8'd0;
    logic       model_vs = 1'b0;

    function automatic logic [23:0] golden(input logic [23:0] rgb, input logic [7:0] t,
                                           input logic [7:0] a);
        int tp, recip, d, p, s;
        logic [23:0] r;
        if (a < 8'd128) return rgb;
        tp    = (t == 8'd0) ? 1 : int'(t);
        recip = 65535 / tp;
        r     = '0;
        for (int c = 0; c < 3; c++) begin
            d = int'(rgb[8*c +: 8]) - int'(a);
            p = d * recip;
            s = (p >>> 8) + int'(a);
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
            r[8*c +: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic drive(input logic [23:0] rgb, input logic [7:0] t, input logic [7:0] a,
                         input logic hs, input logic vs, input logic de);
        bus.i_rgb   = rgb;
        bus.i_trans = t;
        bus.i_atmos = a;
        bus.i_hsync = hs;
        bus.i_vsync = vs;
        bus.i_de    = de;
    endtask

    task automatic add(input logic [23:0] rgb, input logic [7:0] t, input logic [7:0] a,
                       input logic hs, input logic vs, input logic de);
        v_rgb[nvec] = rgb;
        v_t[nvec]   = t;
        v_a[nvec]   = a;
        v_hs[nvec]  = hs;
        v_vs[nvec]  = vs;
        v_de[nvec]  = de;
        nvec++;
    endtask

    // applies v_* one per clock and captures the outputs LAT clocks later
    task automatic run_vectors();
        for (int j = 0; j < nvec + LAT; j++) begin
            @(negedge pixelclk);
            if (j >= LAT) begin
                cap_rgb[j-LAT] = bus.o_rgb;
                cap_hs[j-LAT]  = bus.o_hsync;
                cap_vs[j-LAT]  = bus.o_vsync;
                cap_de[j-LAT]  = bus.o_de;
            end
            if (j < nvec) begin
                drive(v_rgb[j], v_t[j], v_a[j], v_hs[j], v_vs[j], v_de[j]);
                exp_rgb[j] = golden(v_rgb[j], v_t[j], model_a);
                if (v_vs[j] && !model_vs) model_a = v_a[j];
                model_vs = v_vs[j];
            end else begin
                drive(24'h0, 8'h0, bus.i_atmos, 1'b0, 1'b0, 1'b0);
                model_vs = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        drive(24'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge pixelclk);
        n_vec++; if (bus.o_rgb !== 24'h0)   begin n_miss++; $display("FAIL reset_rgb: got %h want %h", bus.o_rgb, 24'h0); end
        n_vec++; if (bus.o_hsync !== 1'b0) begin n_miss++; $display("FAIL reset_hs: got %b want 0", bus.o_hsync); end
        n_vec++; if (bus.o_vsync !== 1'b0) begin n_miss++; $display("FAIL reset_vs: got %b want 0", bus.o_vsync); end
        n_vec++; if (bus.o_de !== 1'b0)    begin n_miss++; $display("FAIL reset_de: got %b want 0", bus.o_de); end
        reset_n  = 1'b1;
        model_a  = 8'd0;
        model_vs = 1'b0;
    endtask

    task automatic test_bypass_frame();
        nvec = 0;
        add(24'h123456, 8'd77,  8'd0,   1'b0, 1'b1, 1'b0);
        add(24'h000000, 8'd0,   8'd200, 1'b0, 1'b1, 1'b0);
        add(24'hA1B2C3, 8'd128, 8'd200, 1'b1, 1'b0, 1'b1);
        add(24'hFF00FF, 8'd0,   8'd200, 1'b0, 1'b0, 1'b1);
        add(24'h010203, 8'd255, 8'd200, 1'b1, 1'b0, 1'b0);
        run_vectors();
        for (int i = 0; i < nvec; i++) begin
            n_vec++;
            if (cap_rgb[i] !== v_rgb[i]) begin
                n_miss++; $display("FAIL bypass_rgb[%0d]: got %h want %h", i, cap_rgb[i], v_rgb[i]);
            end
            n_vec++;
            if ({cap_hs[i], cap_vs[i], cap_de[i]} !== {v_hs[i], v_vs[i], v_de[i]}) begin
                n_miss++; $display("FAIL bypass_sync[%0d]: got %b%b%b want %b%b%b", i,
                                   cap_hs[i], cap_vs[i], cap_de[i], v_hs[i], v_vs[i], v_de[i]);
            end
        end
    endtask

    task automatic test_recover();
        logic [23:0] want [0:10];
        want = '{24'hDCDCDC, 24'hEFEFEF, 24'h000000, 24'hFFFFFF, 24'hC8C8C8, 24'hEF00C8,
                 24'hEFEFEF, 24'h000000, 24'hDCDCDC, 24'h8A8A8A, 24'h939393};
        nvec = 0;
        add(24'hDCDCDC, 8'd128, 8'd200, 1'b0, 1'b1, 1'b1); // vsync rise: old A=0
        add(24'hDCDCDC, 8'd128, 8'd200, 1'b0, 1'b0, 1'b1); // 20*511>>8=39 -> 239
        add(24'h646464, 8'd128, 8'd200, 1'b0, 1'b0, 1'b1); // low clamp
        add(24'hD2D2D2, 8'd26,  8'd200, 1'b1, 1'b0, 1'b1); // 98+200 high clamp
        add(24'hC8C8C8, 8'd0,   8'd200, 1'b0, 1'b0, 1'b1); // t floored to 1
        add(24'hDC64C8, 8'd128, 8'd200, 1'b0, 1'b0, 1'b1); // mixed channels
        add(24'hDCDCDC, 8'd128, 8'd50,  1'b0, 1'b0, 1'b1); // mid-frame A change ignored
        add(24'h000000, 8'd0,   8'd127, 1'b0, 1'b1, 1'b0); // rise latches 127
        add(24'hDCDCDC, 8'd128, 8'd127, 1'b0, 1'b0, 1'b1); // A=127 -> bypass
        add(24'h8A8A8A, 8'd128, 8'd128, 1'b0, 1'b1, 1'b1); // rise latches 128, still bypass
        add(24'h8A8A8A, 8'd128, 8'd128, 1'b0, 1'b0, 1'b1); // 10*511>>8=19 -> 147
        run_vectors();
        for (int i = 0; i < nvec; i++) begin
            n_vec++;
            if (cap_rgb[i] !== want[i]) begin
                n_miss++; $display("FAIL recover_rgb[%0d]: got %h want %h", i, cap_rgb[i], want[i]);
            end
            n_vec++;
            if ({cap_hs[i], cap_vs[i], cap_de[i]} !== {v_hs[i], v_vs[i], v_de[i]}) begin
                n_miss++; $display("FAIL recover_sync[%0d]: got %b%b%b want %b%b%b", i,
                                   cap_hs[i], cap_vs[i], cap_de[i], v_hs[i], v_vs[i], v_de[i]);
            end
        end
    endtask

    task automatic test_line();
        logic [7:0] t;
        nvec = 0;
        add(24'h808080, 8'd100, 8'd200, 1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 1920; j++) begin
            t = 8'($urandom_range(0, 255));
            if (j % 97 == 0) t = 8'd0;
            add(24'($urandom), t, 8'd200, (j < 44), 1'b0, (j >= 88 && j < 1900));
        end
        run_vectors();
        for (int i = 0; i < nvec; i++) begin
            n_vec++;
            if (cap_rgb[i] !== exp_rgb[i]) begin
                n_miss++; $display("FAIL line_rgb[%0d]: got %h want %h", i, cap_rgb[i], exp_rgb[i]);
            end
            n_vec++;
            if (cap_hs[i] !== v_hs[i]) begin
                n_miss++; $display("FAIL line_hs[%0d]: got %b want %b", i, cap_hs[i], v_hs[i]);
            end
            n_vec++;
            if (cap_vs[i] !== v_vs[i]) begin
                n_miss++; $display("FAIL line_vs[%0d]: got %b want %b", i, cap_vs[i], v_vs[i]);
            end
            n_vec++;
            if (cap_de[i] !== v_de[i]) begin
                n_miss++; $display("FAIL line_de[%0d]: got %b want %b", i, cap_de[i], v_de[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] p_rgb [0:39];
        logic        p_hs  [0:39];
        for (int j = 0; j < 30; j++) begin
            @(negedge pixelclk);
            drive(24'h300000 + 24'(j), 8'd90, 8'd200, (j % 5 == 0), 1'b0, 1'b1);
        end
        @(negedge pixelclk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (bus.o_rgb !== 24'h0)   begin n_miss++; $display("FAIL async_rst_rgb: got %h want %h", bus.o_rgb, 24'h0); end
        n_vec++; if (bus.o_de !== 1'b0)    begin n_miss++; $display("FAIL async_rst_de: got %b want 0", bus.o_de); end
        n_vec++; if (bus.o_hsync !== 1'b0) begin n_miss++; $display("FAIL async_rst_hs: got %b want 0", bus.o_hsync); end
        n_vec++; if (bus.o_vsync !== 1'b0) begin n_miss++; $display("FAIL async_rst_vs: got %b want 0", bus.o_vsync); end
        repeat (3) @(negedge pixelclk);
        reset_n  = 1'b1;
        model_a  = 8'd0;
        model_vs = 1'b0;
        for (int j = 0; j < 40; j++) begin
            p_rgb[j] = 24'h5A0000 + 24'(j * 3);
            p_hs[j]  = (j % 7 == 0);
        end
        for (int j = 0; j < LAT + 10; j++) begin
            if (j > 0) @(negedge pixelclk);
            if (j < LAT) begin
                n_vec++;
                if (bus.o_rgb !== 24'h0 || bus.o_de !== 1'b0 || bus.o_hsync !== 1'b0) begin
                    n_miss++; $display("FAIL post_rst_quiet[%0d]: got rgb %h de %b hs %b want all 0",
                                       j, bus.o_rgb, bus.o_de, bus.o_hsync);
                end
            end else begin
                n_vec++;
                if (bus.o_rgb !== p_rgb[j-LAT]) begin
                    n_miss++; $display("FAIL post_rst_rgb[%0d]: got %h want %h", j, bus.o_rgb, p_rgb[j-LAT]);
                end
                n_vec++;
                if (bus.o_de !== 1'b1 || bus.o_hsync !== p_hs[j-LAT]) begin
                    n_miss++; $display("FAIL post_rst_sync[%0d]: got de %b hs %b want de 1 hs %b",
                                       j, bus.o_de, bus.o_hsync, p_hs[j-LAT]);
                end
            end
            drive(p_rgb[j], 8'd64, 8'd200, p_hs[j], 1'b0, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bypass_frame();
        test_recover();
        test_line();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
